// File: rtl/dma_read_buffer.sv
// Read-path buffer behind dma_transfer: reserves FIFO space per read, captures every
// data_out word and re-exports it as a show-ahead valid/ready stream.
module dma_read_buffer #(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned FIFO_ADDR_W = 6,
   parameter int unsigned LEN_W       = 12
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clear,
   input  logic [LEN_W-1:0]       req_length,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   dma_ready,
   output logic                   dma_start,
   input  logic [DATA_W-1:0]      in_data,
   input  logic                   in_valid,
   output logic [DATA_W-1:0]      out_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [FIFO_ADDR_W:0]   level,
   output logic                   overflow
);

   localparam int unsigned          DEPTH     = 2 ** FIFO_ADDR_W;
   localparam logic [FIFO_ADDR_W:0] DEPTH_LVL = (FIFO_ADDR_W + 1)'(DEPTH);
   localparam logic [LEN_W:0]       DEPTH_LEN = (LEN_W + 1)'(DEPTH);

   typedef enum logic [1:0] {StIdle, StWaitBusy, StWaitDone} state_e;

   state_e                 state_q, state_d;
   logic [FIFO_ADDR_W-1:0] wptr_q, rptr_q;
   logic [FIFO_ADDR_W:0]   level_q, level_d;
   logic [FIFO_ADDR_W:0]   resv_q, resv_d;
   logic                   overflow_q, overflow_d;
   logic [DATA_W-1:0]      mem [DEPTH];

   logic [LEN_W:0] need, used, free;
   logic           push, pop;

   // The extra word covers the trailing word burst_align may emit.
   assign need = (({1'b0, req_length} + (LEN_W + 1)'(3)) >> 2) + (LEN_W + 1)'(1);
   assign used = (LEN_W + 1)'(level_q) + (LEN_W + 1)'(resv_q);
   assign free = (used >= DEPTH_LEN) ? '0 : DEPTH_LEN - used;

   assign req_ready = (state_q == StIdle) & dma_ready & ~clear & (need <= free);
   assign dma_start = req_valid & req_ready & (req_length != '0);

   assign out_valid = (level_q != '0);
   assign out_data  = mem[rptr_q];
   assign level     = level_q;
   assign overflow  = overflow_q;

   assign pop  = out_valid & out_ready & ~clear;
   assign push = in_valid & ~clear & ((level_q < DEPTH_LVL) | pop);

   always_comb begin
      state_d    = state_q;
      resv_d     = resv_q;
      level_d    = level_q;
      overflow_d = overflow_q;

      unique case (state_q)
         StIdle:     if (dma_start) state_d = StWaitBusy;
         StWaitBusy: if (!dma_ready) state_d = StWaitDone;
         StWaitDone: if (dma_ready) state_d = StIdle;
         default:    state_d = StIdle;
      endcase

      // FSM-driven reservation changes win over the per-push decrement.
      if (dma_start) begin
         resv_d = resv_q + need[FIFO_ADDR_W:0];
      end else if (state_q == StWaitDone && dma_ready) begin
         resv_d = '0;
      end else if (push && resv_q != '0) begin
         resv_d = resv_q - 1'b1;
      end

      if (push && !pop) begin
         level_d = level_q + 1'b1;
      end else if (pop && !push) begin
         level_d = level_q - 1'b1;
      end

      if (in_valid && !clear && !push) overflow_d = 1'b1;

      if (clear) begin
         resv_d     = '0;
         level_d    = '0;
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         resv_q     <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
         wptr_q     <= '0;
         rptr_q     <= '0;
      end else begin
         state_q    <= state_d;
         resv_q     <= resv_d;
         level_q    <= level_d;
         overflow_q <= overflow_d;
         if (clear) begin
            wptr_q <= '0;
            rptr_q <= '0;
         end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop) rptr_q <= rptr_q + 1'b1;
         end
      end
   end

   // Storage carries no reset; only words below level are ever observed.
   always_ff @(posedge clk) begin
      if (push) mem[wptr_q] <= in_data;
   end

endmodule
